serial_adder: RTL



---
 rtl/serial_adder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from two chained half_adder
// cells plus a carry register. One operand bit pair per cycle, LSB first,
// with a start/busy/done handshake.
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN adds a signed-overflow
// output captured on the final bit.

module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             r_ovf;
`endif

  logic             w_ai;
  logic             w_bi;
  logic             w_s1;
  logic             w_c1;
  logic             w_s;
  logic             w_c2;
  logic             w_cnext;
  logic             w_last;
  logic             w_accept;

  assign w_ai     = r_a[r_idx];
  assign w_bi     = r_b[r_idx];
  assign w_last   = (r_idx == IDXW'(WIDTH - 1));
  assign w_accept = (r_state == S_IDLE) && start;

  // Full adder from two half adders; either carry propagates
  half_adder u_ha0 (
    .i_a (w_ai),
    .i_b (w_bi),
    .o_s (w_s1),
    .o_c (w_c1)
  );

  half_adder u_ha1 (
    .i_a (w_s1),
    .i_b (r_carry),
    .o_s (w_s),
    .o_c (w_c2)
  );

  assign w_cnext = w_c1 | w_c2;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_ADD;
      S_ADD:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Operand shadows, bit index, carry and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= cin;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      r_ovf   <= 1'b0;
`endif
    end else if (r_state == S_ADD) begin
      r_sum[r_idx] <= w_s;
      r_carry      <= w_cnext;
      // Index stops at WIDTH-1 rather than wrapping; reloaded on next start
      if (w_last) begin
        r_cout <= w_cnext;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        r_ovf  <= r_carry ^ w_cnext;
`endif
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign overflow  = r_ovf;
`endif

endmodule
